// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : opcodes, flag indices, FSM encoding and register-file widths
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int REG_AW = 4;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 3;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } ew_state_t;

    function automatic logic [FLAG_W-1:0] mk_flags(input logic c, input logic [DATA_W-1:0] r);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[DATA_W-1];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// mul_iter : radix-2 shift-add multiplier, low 32 bits, 32 iterations
// Revision : 1.0
// ============================================================================
module mul_iter
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic              busy_q;
    logic [5:0]        cnt_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The final sum is exposed combinationally so the owner can capture it
    // on the same edge that performs the 32nd iteration.
    assign product = acc_d;
    assign done    = busy_q && (cnt_q == 6'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_writeback.sv
`default_nettype none
// ============================================================================
// execute_writeback : single-cycle ALU plus iterative MUL, drives RF write port
// Revision : 1.0
// ============================================================================
module execute_writeback
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in_ew,
    input  logic [3:0]        opcode_in_ew,
    input  logic [REG_AW-1:0] dest_in_ew,
    input  logic [DATA_W-1:0] data_s1_in_ew,
    input  logic [DATA_W-1:0] data_s2_in_ew,
    output logic [REG_AW-1:0] dest_out_ew,
    output logic [DATA_W-1:0] data_out_ew,
    output logic [FLAG_W-1:0] flags_out_ew,
    output logic              wr_en_out_ew,
    output logic              stall_out_ew
);

    ew_state_t         state_q, state_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              wr_en_q, wr_en_d;
    logic              stall_q, stall_d;
    logic [REG_AW-1:0] mul_dest_q;

    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_wr;
    logic [4:0]        sh_amt;
    logic [DATA_W:0]   add_w;
    logic [DATA_W:0]   sub_w;
    logic [DATA_W:0]   shl_w;
    logic [DATA_W:0]   shr_w;

    assign sh_amt = data_s2_in_ew[4:0];
    assign add_w  = {1'b0, data_s1_in_ew} + {1'b0, data_s2_in_ew};
    assign sub_w  = {1'b0, data_s1_in_ew} - {1'b0, data_s2_in_ew};
    // Extra bit on the far side of each shift catches the last bit shifted out.
    assign shl_w  = {1'b0, data_s1_in_ew} << sh_amt;
    assign shr_w  = {data_s1_in_ew, 1'b0} >> sh_amt;

    assign mul_start = (state_q == ST_IDLE) && valid_in_ew && (opcode_in_ew == OP_MUL);

    mul_iter u_mul_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (data_s1_in_ew),
        .b       (data_s2_in_ew),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        case (opcode_in_ew)
            OP_ADD: begin
                alu_res = add_w[DATA_W-1:0];
                alu_c   = add_w[DATA_W];
            end
            OP_SUB: begin
                alu_res = sub_w[DATA_W-1:0];
                alu_c   = sub_w[DATA_W];
            end
            OP_AND: alu_res = data_s1_in_ew & data_s2_in_ew;
            OP_OR:  alu_res = data_s1_in_ew | data_s2_in_ew;
            OP_XOR: alu_res = data_s1_in_ew ^ data_s2_in_ew;
            OP_NOT: alu_res = ~data_s1_in_ew;
            OP_MOV: alu_res = data_s1_in_ew;
            OP_SHL: begin
                alu_res = shl_w[DATA_W-1:0];
                alu_c   = shl_w[DATA_W];
            end
            OP_SHR: begin
                alu_res = shr_w[DATA_W:1];
                alu_c   = shr_w[0];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        data_d  = data_q;
        flags_d = flags_q;
        wr_en_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (valid_in_ew) begin
                if (opcode_in_ew == OP_MUL) begin
                    state_d = ST_MUL_BUSY;
                end else if (alu_wr) begin
                    dest_d  = dest_in_ew;
                    data_d  = alu_res;
                    flags_d = mk_flags(alu_c, alu_res);
                    wr_en_d = 1'b1;
                end
            end
        end else begin
            if (mul_done) begin
                dest_d  = mul_dest_q;
                data_d  = mul_product;
                flags_d = mk_flags(1'b0, mul_product);
                wr_en_d = 1'b1;
                state_d = ST_IDLE;
            end
        end
        stall_d = (state_d == ST_MUL_BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dest_q     <= '0;
            data_q     <= '0;
            flags_q    <= '0;
            wr_en_q    <= 1'b0;
            stall_q    <= 1'b0;
            mul_dest_q <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            wr_en_q <= wr_en_d;
            stall_q <= stall_d;
            if (mul_start) begin
                mul_dest_q <= dest_in_ew;
            end
        end
    end

    assign dest_out_ew  = dest_q;
    assign data_out_ew  = data_q;
    assign flags_out_ew = flags_q;
    assign wr_en_out_ew = wr_en_q;
    assign stall_out_ew = stall_q;

endmodule
`default_nettype wire

// File: doc/execute_writeback.md
# execute_writeback

Execute/writeback stage of the four-stage pipelined controller. It takes the two operand words read from `internal_register`, an opcode and a destination index from decode, and computes a 32-bit result with three flags. It drives the register file's write port (`dest`, `data`, `flags`). Single-cycle ALU ops complete in one clock; MUL is iterative and stalls upstream until it finishes.

## Interface
- No parameters. Widths are fixed by the register file: 16 registers, 32-bit data, 3 flags.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset  in  1` — asynchronous, active-high; clears all state.
- `valid_in_ew  in  1` — opcode, dest and operands are valid this cycle.
- `opcode_in_ew  in  4` — operation select.
- `dest_in_ew  in  4` — destination register index.
- `data_s1_in_ew  in  32` — operand 1, from `data_s1_out_ir`.
- `data_s2_in_ew  in  32` — operand 2, from `data_s2_out_ir`.
- `dest_out_ew  out  4` — drives `dest_in_ir`.
- `data_out_ew  out  32` — drives `data_in_ir`.
- `flags_out_ew  out  3` — drives `flags_in_ir`: [2]=C, [1]=Z, [0]=N.
- `wr_en_out_ew  out  1` — one-cycle pulse when a new result is presented. Used for trace and hazard logic.
- `stall_out_ew  out  1` — upstream must hold all inputs while this is high.

## Operation
- The register file writes its port on every clock with no enable. Outputs therefore hold the last result whenever no new result is produced. A repeated write of an identical value is harmless.
- Reset values: `dest_out_ew`=0, `data_out_ew`=0, `flags_out_ew`=0, `wr_en_out_ew`=0, `stall_out_ew`=0, state=IDLE. After reset, R0 is written with 0.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (s1−s2)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT s1
  - 7 MOV s1
  - 8 SHL s1 by s2[4:0]
  - 9 SHR (logical) s1 by s2[4:0]
  - 10 MUL, low 32 bits of the unsigned product
  - 11–15 behave as NOP
- Flag rules:
  - Z = (result==0).
  - N = result[31].
  - C for ADD = carry out of bit 31.
  - C for SUB = borrow, i.e. 1 when s1 < s2 unsigned.
  - C for SHL/SHR = the last bit shifted out; 0 when the shift amount is 0.
  - C = 0 for all other ops, including MUL.
- NOP or reserved opcode with `valid_in_ew`=1: outputs hold, `wr_en_out_ew`=0.
- State machine (two states):
  - IDLE: on valid with a non-MUL op, register the result, set `wr_en_out_ew`=1 and stay in IDLE. On valid MUL, latch the operands and dest, clear the iteration counter, go to MUL_BUSY.
  - MUL_BUSY: one shift-add iteration per clock, 32 iterations in total. On the 32nd iteration, register the result, dest and flags, pulse `wr_en_out_ew` and return to IDLE.
- `stall_out_ew` is registered and equals (state==MUL_BUSY).
- `valid_in_ew` is ignored while in MUL_BUSY.
- MUL operands and dest are latched at accept. Upstream changes during the stall do not affect the result.

## Timing
- Single-cycle ops: a valid op sampled at edge k produces its result on the outputs after edge k, with `wr_en_out_ew` high for cycle k..k+1 only.
- Back-to-back single-cycle ops are accepted every clock with no stall.
- MUL accepted at edge k:
  - `stall_out_ew` is high from after edge k until after edge k+32.
  - The result appears after edge k+32.
  - Outputs hold the previous result during cycles k+1..k+31.
  - The next instruction can be accepted at edge k+33.
- Reset asserted mid-MUL: the MUL aborts immediately and everything returns to reset values. No partial result is ever presented.
- Reset deasserted: the first valid input can be accepted on the first rising edge.

## Structure
- Shared package `pipe_pkg` holds:
  - opcode localparams (`OP_NOP`..`OP_MUL`)
  - flag bit indices (`FLAG_C`=2, `FLAG_Z`=1, `FLAG_N`=0)
  - the FSM state encoding
  - register-file width constants (`REG_AW`=4, `DATA_W`=32, `FLAG_W`=3)
- Sub-module `mul_iter`: radix-2 sequential multiplier. Interface is `start`, `a`, `b`, `done`, `product[31:0]`, with its own 6-bit counter. `execute_writeback` owns the FSM and the output registers.

## Test plan
- ADD s1=0xFFFFFFFF, s2=1, dest=3 → `data_out_ew`=0, flags C=1 Z=1 N=0, `dest_out_ew`=3, one `wr_en_out_ew` pulse.
- SUB s1=5, s2=7 → 0xFFFFFFFE, C=1 Z=0 N=1. Then SHL s1=0x80000001, s2=1 on the next clock → 0x00000002, C=1, with no stall between the two.
- MUL s1=123, s2=456, dest=9 → `stall_out_ew` high exactly 32 cycles; result 56088, flags 0. Inputs changed during the stall are ignored.
- MUL s1=0x10000, s2=0x10000 → result 0, Z=1, C=0.
- Reset pulsed at cycle 10 of a MUL → all outputs 0, stall 0, state IDLE. A following ADD 2+3 gives 5 one clock after acceptance.
- `valid_in_ew`=0 for 5 cycles, then opcode 13 with valid → outputs hold the last result, `wr_en_out_ew` stays 0.
